// File: rtl/wb_commit.sv
// Architectural-state commit: 32x32 GPR file, HI/LO pair and LLbit, with two ID read ports.
// Optional same-cycle write-to-read forwarding enabled by defining WB_BYPASS_EN.
module wb_commit #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              flush,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              LLbit_o
);

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              llbit_q;

  // NOTE: the whole file is reset because architectural state must read zero
  // after reset; this costs a reset net per flop, unlike a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wb_wreg && (wb_wd != 5'd0)) begin
      // NOTE: non-blocking assignment for all state so every update
      // commits on the same edge regardless of process ordering.
      regs[wb_wd] <= wb_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  // flush wins over a simultaneous LLbit write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              llbit_q <= 1'b0;
    else if (flush)       llbit_q <= 1'b0;
    else if (wb_LLbit_we) llbit_q <= wb_LLbit_value;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves the output unassigned
    // (which would infer a latch).
    rdata1 = '0;
    if (re1 && (raddr1 != 5'd0)) begin
      rdata1 = regs[raddr1];
`ifdef WB_BYPASS_EN
      if (!rst && wb_wreg && (wb_wd == raddr1)) rdata1 = wb_wdata;
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (re2 && (raddr2 != 5'd0)) begin
      rdata2 = regs[raddr2];
`ifdef WB_BYPASS_EN
      if (!rst && wb_wreg && (wb_wd == raddr2)) rdata2 = wb_wdata;
`endif
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    hi_o    = hi_q;
    lo_o    = lo_q;
    LLbit_o = llbit_q;
    if (!rst) begin
      if (wb_whilo) begin
        hi_o = wb_hi;
        lo_o = wb_lo;
      end
      if (flush)            LLbit_o = 1'b0;
      else if (wb_LLbit_we) LLbit_o = wb_LLbit_value;
    end
  end
`else
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign LLbit_o = llbit_q;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: stimulus queues expected outputs, a negedge monitor compares.
// Expectations for same-cycle visibility follow WB_BYPASS_EN when it is defined.
module tb_wb_commit;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_whilo, wb_LLbit_we, wb_LLbit_value, flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o;
  logic        LLbit_o;

  wb_commit dut (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .flush(flush),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
  );

  always #5 clk = ~clk;

  typedef enum int {S_RD1, S_RD2, S_HI, S_LO, S_LL} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        S_RD1:   mon_act = rdata1;
        S_RD2:   mon_act = rdata2;
        S_HI:    mon_act = hi_o;
        S_LO:    mon_act = lo_o;
        default: mon_act = {31'd0, LLbit_o};
      endcase
      check(mon_e.name, mon_act, mon_e.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_wd = '0; wb_wreg = 0; wb_wdata = '0;
    wb_hi = '0; wb_lo = '0; wb_whilo = 0;
    wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    re1 = 1; raddr1 = 5'd5; re2 = 0; raddr2 = 5'd0;

    step();
    expect_out("reset_rd1", S_RD1, 32'h0);
    expect_out("reset_hi",  S_HI,  32'h0);
    expect_out("reset_lo",  S_LO,  32'h0);
    expect_out("reset_ll",  S_LL,  32'h0);

    // GPR 5 write
    step();
    rst = 0;
    wb_wreg = 1; wb_wd = 5'd5; wb_wdata = 32'hDEADBEEF;
    expect_out("wr5_same_cycle", S_RD1, BYP ? 32'hDEADBEEF : 32'h0);

    step();
    idle();
    re1 = 1; raddr1 = 5'd5; re2 = 1; raddr2 = 5'd5;
    expect_out("wr5_rd1", S_RD1, 32'hDEADBEEF);
    expect_out("wr5_rd2_same_reg", S_RD2, 32'hDEADBEEF);

    // Write to register 0 is discarded; disabled port reads 0
    step();
    wb_wreg = 1; wb_wd = 5'd0; wb_wdata = 32'h12345678;
    re1 = 1; raddr1 = 5'd0; re2 = 0; raddr2 = 5'd5;
    expect_out("r0_before", S_RD1, 32'h0);
    expect_out("re2_off",   S_RD2, 32'h0);

    step();
    idle();
    re2 = 1;
    expect_out("r0_after", S_RD1, 32'h0);
    expect_out("r5_kept",  S_RD2, 32'hDEADBEEF);

    // HI/LO write then hold
    step();
    wb_whilo = 1; wb_hi = 32'hAAAA0000; wb_lo = 32'h0000BBBB;
    expect_out("hilo_same_hi", S_HI, BYP ? 32'hAAAA0000 : 32'h0);
    expect_out("hilo_same_lo", S_LO, BYP ? 32'h0000BBBB : 32'h0);

    step();
    wb_whilo = 0; wb_hi = 32'h1; wb_lo = 32'h2;
    expect_out("hi_hold", S_HI, 32'hAAAA0000);
    expect_out("lo_hold", S_LO, 32'h0000BBBB);

    // LLbit set, then flush beats a simultaneous set
    step();
    idle();
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_out("ll_same", S_LL, BYP ? 32'h1 : 32'h0);

    step();
    flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_out("ll_set", S_LL, BYP ? 32'h0 : 32'h1);

    step();
    idle();
    expect_out("ll_flush_wins", S_LL, 32'h0);

    // Independent same-edge updates: GPR 7, HI/LO, LLbit
    step();
    wb_wreg = 1; wb_wd = 5'd7; wb_wdata = 32'h55;
    wb_whilo = 1; wb_hi = 32'h11; wb_lo = 32'h22;
    wb_LLbit_we = 1; wb_LLbit_value = 1;

    step();
    idle();
    re1 = 1; raddr1 = 5'd7;
    expect_out("r7_loaded", S_RD1, 32'h55);
    expect_out("hi_loaded", S_HI,  32'h11);
    expect_out("lo_loaded", S_LO,  32'h22);
    expect_out("ll_loaded", S_LL,  32'h1);

    // Asynchronous reset between edges, with a write in flight
    step();
    rst = 1;
    wb_wreg = 1; wb_wd = 5'd7; wb_wdata = 32'h99;
    wb_whilo = 1; wb_hi = 32'h77; wb_lo = 32'h88;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_out("async_rst_r7", S_RD1, 32'h0);
    expect_out("async_rst_hi", S_HI,  32'h0);
    expect_out("async_rst_lo", S_LO,  32'h0);
    expect_out("async_rst_ll", S_LL,  32'h0);

    step();
    expect_out("rst_held_r7", S_RD1, 32'h0);
    expect_out("rst_held_hi", S_HI,  32'h0);

    step();
    rst = 0;
    idle();
    expect_out("post_rst_r7", S_RD1, 32'h0);
    expect_out("post_rst_hi", S_HI,  32'h0);
    expect_out("post_rst_ll", S_LL,  32'h0);

    step();
    re2 = 1; raddr2 = 5'd5;
    expect_out("post_rst_edge_r7", S_RD1, 32'h0);
    expect_out("post_rst_edge_r5", S_RD2, 32'h0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Architectural-state commit block at the far end of the MEM/WB pipeline register; consumes the wb_* bundle it emits.
- Holds the 32x32 general register file, the HI/LO pair and the LLbit.
- Provides the two ID-stage read ports plus HI/LO and LLbit read-out for EX/MEM.
- Sole owner of architectural register state; all retirement writes land here.

Parameters:
- REG_NUM, 32, number of general registers; register 0 is hardwired to zero.
- DATA_W, 32, register, HI and LO data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- wb_wd  input  5  GPR write address.
- wb_wreg  input  1  GPR write enable.
- wb_wdata  input  32  GPR write data.
- wb_hi  input  32  HI write data.
- wb_lo  input  32  LO write data.
- wb_whilo  input  1  HI/LO write enable; writes both registers together.
- wb_LLbit_we  input  1  LLbit write enable.
- wb_LLbit_value  input  1  LLbit write value.
- flush  input  1  exception/ERET flush; clears LLbit.
- re1  input  1  read-port-1 enable.
- raddr1  input  5  read-port-1 address.
- rdata1  output  32  read-port-1 data.
- re2  input  1  read-port-2 enable.
- raddr2  input  5  read-port-2 address.
- rdata2  output  32  read-port-2 data.
- hi_o  output  32  current HI value.
- lo_o  output  32  current LO value.
- LLbit_o  output  1  current LLbit value.

Behaviour:
- Reset: on rst=1, asynchronously clear all GPRs, HI, LO and LLbit to 0. While rst=1, every output reads 0, including read ports addressing written registers. Reset asserted mid-write aborts that write; nothing from that cycle survives.
- GPR write: at posedge, when wb_wreg=1 and wb_wd!=0, regs[wb_wd] <= wb_wdata. Writes to address 0 are discarded.
- Read ports are combinational, zero latency. Output is 0 when:
  - reN=0, or
  - raddrN=0.
  Otherwise output is regs[raddrN], subject to the optional bypass.
- Both read ports may address the same register; each returns identical data.
- HI/LO: at posedge, when wb_whilo=1, HI <= wb_hi and LO <= wb_lo together. No partial write exists.
- LLbit update priority at posedge:
  1. flush=1 -> LLbit <= 0. This wins over a simultaneous wb_LLbit_we=1.
  2. else wb_LLbit_we=1 -> LLbit <= wb_LLbit_value.
  3. else LLbit holds.
- flush does not gate GPR or HI/LO writes. The upstream pipeline register already nulls the bundle on flush.
- GPR, HI/LO and LLbit updates in the same cycle are independent; all commit on the same edge.
- No stall input: the incoming bundle is already NOP-filled during stalls, so every cycle with enables set commits.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-to-read forwarding, so same-cycle writes are visible on the outputs.
  - If reN=1, raddrN!=0, wb_wreg=1 and wb_wd==raddrN, then rdataN = wb_wdata.
  - If wb_whilo=1, then hi_o = wb_hi and lo_o = wb_lo.
  - LLbit_o = 0 if flush=1; else wb_LLbit_value if wb_LLbit_we=1; else stored LLbit.
  - Bypass is suppressed while rst=1.
- Not defined: all outputs reflect stored state only. Writes become visible the cycle after the commit edge, and the ID stage must cover the one-cycle hazard.

Test Plan:
- Reset, then wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF for one edge; re1=1, raddr1=5 -> rdata1=0xDEADBEEF after the edge. With WB_BYPASS_EN, it also appears in the write cycle itself.
- wb_wreg=1, wb_wd=0, wb_wdata=0x12345678; re1=1, raddr1=0 -> rdata1=0 both before and after the edge. re2=0 with raddr2=5 -> rdata2=0.
- wb_whilo=1, wb_hi=0xAAAA0000, wb_lo=0x0000BBBB for one edge, then wb_whilo=0 with new data -> hi_o=0xAAAA0000 and lo_o=0x0000BBBB hold.
- wb_LLbit_we=1, wb_LLbit_value=1 -> LLbit_o=1. Next edge: flush=1 together with wb_LLbit_we=1, wb_LLbit_value=1 -> LLbit_o=0.
- Load GPR 7=0x55, HI=0x11, LLbit=1; assert rst between clock edges -> rdata1 (raddr1=7), hi_o and LLbit_o read 0 immediately without a clock edge, and stay 0 after rst deasserts.
